// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared FSM encoding and tag/beat helpers for the tagged frame decoder
package uart_frame_pkg;
    typedef enum logic {COLLECT = 1'b0, VALID = 1'b1} state_t;

    function automatic int beats(input int nb_operand, input int nb_payload);
        return nb_operand / nb_payload;
    endfunction

    function automatic int tag_opcode(input int n_operands);
        return n_operands;
    endfunction

    function automatic int tag_clear(input int nb_tag);
        return (1 << nb_tag) - 1;
    endfunction
endpackage

// File: rtl/operand_assembler.sv
// operand_assembler: builds one multi-beat operand LSB-first with a beat counter and ready flag
module operand_assembler
    import uart_frame_pkg::*;
#(
    parameter int NB_PAYLOAD = 8,
    parameter int NB_OPERAND = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr,
    input  logic                  abort,
    input  logic                  clear,
    input  logic [NB_PAYLOAD-1:0] payload,
    output logic [NB_OPERAND-1:0] operand,
    output logic                  ready,
    output logic                  ready_nxt,
    output logic                  partial
);
    localparam int BEATS = beats(NB_OPERAND, NB_PAYLOAD);
    localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;

    logic [BW-1:0] beat;
    logic last;

    assign last = beat == BW'(BEATS - 1);
    // a write at beat 0 drops ready, so only the final beat can raise it
    assign ready_nxt = clear ? 1'b0 : wr ? last : ready;
    assign partial = beat != '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            operand <= '0;
            beat <= '0;
            ready <= 1'b0;
        end else begin
            ready <= ready_nxt;
            if (clear || abort) begin
                beat <= '0;
            end else if (wr) begin
                operand[int'(beat)*NB_PAYLOAD +: NB_PAYLOAD] <= payload;
                beat <= last ? '0 : beat + 1'b1;
            end
        end
    end
endmodule

// File: rtl/uart_tagged_frame_decoder.sv
// uart_tagged_frame_decoder: turns tagged UART frames into an operand/opcode set for the ALU
module uart_tagged_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int NB_PAYLOAD = 8,
    parameter int NB_TAG     = 2,
    parameter int NB_OPERAND = 16,
    parameter int NB_OPCODE  = 6,
    parameter int N_OPERANDS = 2
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_rx_done,
    input  logic [NB_PAYLOAD+NB_TAG-1:0]     i_rx_data,
    input  logic                             i_frame_err,
    input  logic                             i_result_ack,
    output logic [N_OPERANDS*NB_OPERAND-1:0] o_operands,
    output logic [NB_OPCODE-1:0]             o_opcode,
    output logic [N_OPERANDS-1:0]            o_operand_ready,
    output logic                             o_opcode_ready,
    output logic                             o_data_valid,
    output logic                             o_err_seq,
    output logic                             o_err_busy,
    output logic                             o_frame_err
);
    localparam logic [NB_TAG-1:0] TAG_OPC = NB_TAG'(tag_opcode(N_OPERANDS));
    localparam logic [NB_TAG-1:0] TAG_CLR = NB_TAG'(tag_clear(NB_TAG));

    logic [NB_TAG-1:0] tag;
    logic [NB_PAYLOAD-1:0] payload;
    logic frame, clear, wr_opc, opc_rdy_nxt, go_valid;
    logic err_seq_nxt, err_busy_nxt, ferr_nxt;
    logic [N_OPERANDS-1:0] wr, abort, partial, rdy_nxt;
    state_t state, state_nxt;

    assign tag = i_rx_data[NB_PAYLOAD+NB_TAG-1 -: NB_TAG];
    assign payload = i_rx_data[NB_PAYLOAD-1:0];
    assign frame = i_rx_done & ~i_frame_err;
    assign o_data_valid = state == VALID;
    assign opc_rdy_nxt = clear ? 1'b0 : wr_opc ? 1'b1 : o_opcode_ready;
    assign go_valid = state == COLLECT && frame && (&rdy_nxt) && opc_rdy_nxt;

    always_comb begin
        wr = '0;
        abort = '0;
        clear = 1'b0;
        wr_opc = 1'b0;
        err_seq_nxt = 1'b0;
        err_busy_nxt = 1'b0;
        ferr_nxt = o_frame_err | (i_rx_done & i_frame_err);
        if (state == VALID) begin
            clear = i_result_ack | (frame & tag == TAG_CLR);
            err_busy_nxt = frame & (i_result_ack | tag != TAG_CLR);
            ferr_nxt = (!i_result_ack && frame && tag == TAG_CLR) ? 1'b0 : ferr_nxt;
        end else if (frame) begin
            // any frame not for the partial channel abandons that channel's beats
            for (int k = 0; k < N_OPERANDS; k++) begin
                wr[k] = tag == NB_TAG'(k);
                abort[k] = !wr[k] && partial[k];
            end
            wr_opc = tag == TAG_OPC;
            clear = tag == TAG_CLR;
            ferr_nxt = clear ? 1'b0 : ferr_nxt;
            err_seq_nxt = (|abort) | (!(|wr) && !wr_opc && !clear);
        end
    end

    always_comb begin
        state_nxt = state;
        if (state == VALID && clear)
            state_nxt = COLLECT;
        else if (go_valid)
            state_nxt = VALID;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset)
            state <= COLLECT;
        else
            state <= state_nxt;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_opcode <= '0;
            o_opcode_ready <= 1'b0;
            o_err_seq <= 1'b0;
            o_err_busy <= 1'b0;
            o_frame_err <= 1'b0;
        end else begin
            if (wr_opc)
                o_opcode <= payload[NB_OPCODE-1:0];
            o_opcode_ready <= opc_rdy_nxt;
            o_err_seq <= err_seq_nxt;
            o_err_busy <= err_busy_nxt;
            o_frame_err <= ferr_nxt;
        end
    end

    for (genvar k = 0; k < N_OPERANDS; k++) begin : g_asm
        operand_assembler #(
            .NB_PAYLOAD(NB_PAYLOAD),
            .NB_OPERAND(NB_OPERAND)
        ) u_asm (
            .clk      (i_clk),
            .rst      (i_reset),
            .wr       (wr[k]),
            .abort    (abort[k]),
            .clear    (clear),
            .payload  (payload),
            .operand  (o_operands[k*NB_OPERAND +: NB_OPERAND]),
            .ready    (o_operand_ready[k]),
            .ready_nxt(rdy_nxt[k]),
            .partial  (partial[k])
        );
    end
endmodule
